// File: rtl/alu_pkg.sv
// Shared types for the dispatch stage, the ALU and the verification environment:
// ALU opcodes, RV32I opcode constants, dispatch FSM states and the decoded-instruction record.
package alu_pkg;

  localparam int unsigned DataW = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } dispatch_state_e;

  typedef struct packed {
    alu_op_e          op;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [DataW-1:0] imm;
    logic             use_imm;
    logic             legal;
  } decoded_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I OP / OP-IMM decoder: instruction word -> decoded_t.
// Anything outside those two opcodes, or a funct7 that does not fit its funct3, is flagged illegal.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    dec         = '0;
    dec.op      = ALU_ADD;
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    if (opcode == OPC_OP) begin
      // Only ADD/SUB and SRL/SRA use the alternate funct7.
      dec.legal = (funct7 == 7'h00) ||
                  ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
      case (funct3)
        3'd0:    dec.op = funct7[5] ? ALU_SUB : ALU_ADD;
        3'd1:    dec.op = ALU_SLL;
        3'd2:    dec.op = ALU_SLT;
        3'd3:    dec.op = ALU_SLTU;
        3'd4:    dec.op = ALU_XOR;
        3'd5:    dec.op = funct7[5] ? ALU_SRA : ALU_SRL;
        3'd6:    dec.op = ALU_OR;
        default: dec.op = ALU_AND;
      endcase
    end else if (opcode == OPC_OPIMM) begin
      dec.use_imm = 1'b1;
      dec.legal   = 1'b1;
      dec.imm     = {{(DataW-12){instr[31]}}, instr[31:20]};
      case (funct3)
        3'd0: dec.op = ALU_ADD;
        3'd1: begin
          dec.op    = ALU_SLL;
          dec.imm   = {{(DataW-5){1'b0}}, instr[24:20]};
          dec.legal = (funct7 == 7'h00);
        end
        3'd2: dec.op = ALU_SLT;
        3'd3: dec.op = ALU_SLTU;
        3'd4: dec.op = ALU_XOR;
        3'd5: begin
          dec.op    = funct7[5] ? ALU_SRA : ALU_SRL;
          dec.imm   = {{(DataW-5){1'b0}}, instr[24:20]};
          dec.legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        end
        3'd6:    dec.op = ALU_OR;
        default: dec.op = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// Issue/writeback stage in front of the ALU: decode, read regfile, issue, wait for exec, write rd.
// Optional ALU_DISPATCH_FWD_EN adds a 1-entry skid buffer with result forwarding into the next issue.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NREGS          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output alu_op_e         alu_instr,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic            alu_enable,
  input  logic            alu_instr_exec,
  input  logic [XLEN-1:0] alu_result,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            illegal,
  output logic            timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  dispatch_state_e state_q, state_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [CntW-1:0] cnt_q;
  alu_op_e         op_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic [4:0]      rd_q;
  logic            illegal_q, timeout_q;

  decoded_t dec;
  decoded_t issue_dec;
  logic     accept, wb_en, tmo_hit, issue_ld, issue_fwd;

  alu_decode u_decode (
    .instr (in_instr),
    .dec   (dec)
  );

  assign accept  = in_valid && in_ready;
  assign wb_en   = (state_q == StWait) && alu_instr_exec && (rd_q != 5'd0);
  assign tmo_hit = (state_q == StWait) && !alu_instr_exec &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

`ifdef ALU_DISPATCH_FWD_EN
  decoded_t buf_q;
  logic     buf_valid_q;
  logic     wait_done;

  assign wait_done = (state_q == StWait) && (alu_instr_exec || tmo_hit);
  // On leaving WAIT, issue straight away from the buffer, or from a legal word arriving now.
  assign issue_dec = buf_valid_q ? buf_q : dec;
  assign issue_fwd = wait_done;
  assign issue_ld  = (accept && dec.legal && (state_q == StIdle)) ||
                     (wait_done && (buf_valid_q || (accept && dec.legal)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
    end else if (wait_done) begin
      buf_valid_q <= 1'b0;
    end else if (accept && dec.legal && (state_q == StWait)) begin
      buf_q       <= dec;
      buf_valid_q <= 1'b1;
    end
  end
`else
  assign issue_dec = dec;
  assign issue_fwd = 1'b0;
  assign issue_ld  = accept && dec.legal && (state_q == StIdle);
`endif

  // x0 reads zero; optionally take the value being written back this cycle.
  function automatic logic [XLEN-1:0] src_val(input logic [4:0] idx, input logic fwd);
    if (idx == 5'd0) return '0;
    if (fwd && wb_en && (idx == rd_q)) return alu_result;
    return rf_q[idx];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (issue_ld) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (alu_instr_exec || tmo_hit) state_d = issue_ld ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
`ifdef ALU_DISPATCH_FWD_EN
    if ((state_q == StWait) && !buf_valid_q) in_ready = 1'b1;
`endif
    alu_enable = (state_q == StIssue);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      op_q      <= ALU_ADD;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      illegal_q <= accept && !dec.legal;
      timeout_q <= tmo_hit;
      if (state_q == StIssue) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (issue_ld) begin
        op_q  <= issue_dec.op;
        op1_q <= src_val(issue_dec.rs1, issue_fwd);
        op2_q <= issue_dec.use_imm ? XLEN'(issue_dec.imm) : src_val(issue_dec.rs2, issue_fwd);
        rd_q  <= issue_dec.rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[rd_q] <= alu_result;
    end
  end

  assign alu_instr = op_q;
  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign illegal   = illegal_q;
  assign timeout   = timeout_q;
  assign dbg_data  = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed scenarios plus random OP/OP-IMM traffic,
// checked against a table-driven decode model and a plain-arithmetic ALU model.
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [3:0]  alu_instr;
  logic [31:0] alu_op1, alu_op2;
  logic        alu_enable;
  logic        alu_instr_exec;
  logic [31:0] alu_result;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        illegal;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mregs [32];
  int          op_tab [int];

  alu_dispatch dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .alu_instr      (alu_instr),
    .alu_op1        (alu_op1),
    .alu_op2        (alu_op2),
    .alu_enable     (alu_enable),
    .alu_instr_exec (alu_instr_exec),
    .alu_result     (alu_result),
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data),
    .illegal        (illegal),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input int op);
    op_tab[int'({opc, f3, f7})] = op;
  endtask

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Expected decode: legality and opcode come from the instruction table, operands from mregs.
  task automatic ref_dec(input logic [31:0] ins, output bit legal, output int op,
                         output logic [4:0] rd, output logic [31:0] a, output logic [31:0] b);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         is_imm, is_sh;
    int         k;
    opc    = ins[6:0];
    f3     = ins[14:12];
    f7     = ins[31:25];
    is_imm = (opc == 7'b0010011);
    is_sh  = is_imm && (f3 == 3'd1 || f3 == 3'd5);
    k      = int'({opc, f3, (is_imm && !is_sh) ? 7'h00 : f7});
    legal  = op_tab.exists(k);
    op     = legal ? op_tab[k] : 0;
    rd     = ins[11:7];
    a      = mregs[ins[19:15]];
    if (!is_imm)    b = mregs[ins[24:20]];
    else if (is_sh) b = {27'd0, ins[24:20]};
    else            b = {{20{ins[31]}}, ins[31:20]};
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      0:       return a + b;
      1:       return a - b;
      2:       return a << b[4:0];
      3:       return {31'd0, $signed(a) < $signed(b)};
      4:       return {31'd0, a < b};
      5:       return a ^ b;
      6:       return a >> b[4:0];
      7:       return 32'($signed(a) >>> b[4:0]);
      8:       return a | b;
      default: return a & b;
    endcase
  endfunction

  // Send one instruction, act as the ALU (or stay silent), and check every visible step.
  task automatic do_instr(input logic [31:0] ins, input int delay, input bit give_exec);
    bit          legal;
    int          op;
    int          n;
    logic [4:0]  rd;
    logic [31:0] a, b, res;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk1("ready_before_issue", in_ready, 1'b1);
    ref_dec(ins, legal, op, rd, a, b);
    in_valid = 1'b1;
    in_instr = ins;
    tick();
    in_valid = 1'b0;
    in_instr = $urandom;
    if (!legal) begin
      chk1("illegal_pulse", illegal, 1'b1);
      chk1("illegal_no_enable", alu_enable, 1'b0);
      chk1("illegal_ready", in_ready, 1'b1);
      tick();
      chk1("illegal_one_cycle", illegal, 1'b0);
      chk1("illegal_no_enable2", alu_enable, 1'b0);
      return;
    end
    chk1("issue_enable", alu_enable, 1'b1);
    chk("issue_alu_instr", 32'(alu_instr), 32'(op));
    chk("issue_op1", alu_op1, a);
    chk("issue_op2", alu_op2, b);
    chk1("issue_not_ready", in_ready, 1'b0);
    chk1("issue_no_illegal", illegal, 1'b0);
    res = ref_alu(op, a, b);
    tick();
    chk1("wait_enable_low", alu_enable, 1'b0);
    chk("wait_op1_hold", alu_op1, a);
    chk("wait_op2_hold", alu_op2, b);
    if (!give_exec) begin
      for (int i = 1; i < 16; i++) begin
        tick();
        chk1("timeout_early", timeout, 1'b0);
        chk1("timeout_waiting", in_ready, 1'b0);
      end
      tick();
      chk1("timeout_pulse", timeout, 1'b1);
      chk1("timeout_ready", in_ready, 1'b1);
      dbg_addr = rd;
      #1;
      chk("timeout_rd_unchanged", dbg_data, mregs[rd]);
      tick();
      chk1("timeout_one_cycle", timeout, 1'b0);
      return;
    end
    repeat (delay) tick();
    alu_instr_exec = 1'b1;
    alu_result     = res;
    dbg_addr       = rd;
    #1;
    chk("no_write_through", dbg_data, mregs[rd]);
    chk1("exec_cycle_no_timeout", timeout, 1'b0);
    tick();
    alu_instr_exec = 1'b0;
    alu_result     = $urandom;
    if (rd != 5'd0) mregs[rd] = res;
    chk1("ready_after_exec", in_ready, 1'b1);
    chk1("no_timeout_after_exec", timeout, 1'b0);
    chk1("enable_low_after_exec", alu_enable, 1'b0);
    #1;
    chk("writeback_rd", dbg_data, mregs[rd]);
  endtask

  initial begin
    add_op(7'b0110011, 3'd0, 7'h00, 0);
    add_op(7'b0110011, 3'd0, 7'h20, 1);
    add_op(7'b0110011, 3'd1, 7'h00, 2);
    add_op(7'b0110011, 3'd2, 7'h00, 3);
    add_op(7'b0110011, 3'd3, 7'h00, 4);
    add_op(7'b0110011, 3'd4, 7'h00, 5);
    add_op(7'b0110011, 3'd5, 7'h00, 6);
    add_op(7'b0110011, 3'd5, 7'h20, 7);
    add_op(7'b0110011, 3'd6, 7'h00, 8);
    add_op(7'b0110011, 3'd7, 7'h00, 9);
    add_op(7'b0010011, 3'd0, 7'h00, 0);
    add_op(7'b0010011, 3'd1, 7'h00, 2);
    add_op(7'b0010011, 3'd2, 7'h00, 3);
    add_op(7'b0010011, 3'd3, 7'h00, 4);
    add_op(7'b0010011, 3'd4, 7'h00, 5);
    add_op(7'b0010011, 3'd5, 7'h00, 6);
    add_op(7'b0010011, 3'd5, 7'h20, 7);
    add_op(7'b0010011, 3'd6, 7'h00, 8);
    add_op(7'b0010011, 3'd7, 7'h00, 9);
    for (int i = 0; i < 32; i++) mregs[i] = '0;

    rst            = 1'b0;
    in_valid       = 1'b0;
    in_instr       = '0;
    alu_instr_exec = 1'b0;
    alu_result     = '0;
    dbg_addr       = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_ready", in_ready, 1'b1);
    chk1("reset_enable", alu_enable, 1'b0);
    chk("reset_alu_instr", 32'(alu_instr), 32'd0);
    chk("reset_op1", alu_op1, 32'd0);
    chk("reset_op2", alu_op2, 32'd0);
    chk1("reset_illegal", illegal, 1'b0);
    chk1("reset_timeout", timeout, 1'b0);
    chk("reset_reg", dbg_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Directed scenarios.
    do_instr(i_type(12'd5, 5'd0, 3'd0, 5'd1), 0, 1'b1);
    do_instr(i_type(12'd7, 5'd0, 3'd0, 5'd1), 0, 1'b1);
    do_instr(i_type(12'd3, 5'd0, 3'd0, 5'd2), 1, 1'b1);
    do_instr(r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 0, 1'b1);
    dbg_addr = 5'd3;
    #1;
    chk("sub_result_x3", dbg_data, 32'd4);
    do_instr(i_type(12'd9, 5'd0, 3'd0, 5'd0), 0, 1'b1);
    dbg_addr = 5'd0;
    #1;
    chk("x0_stays_zero", dbg_data, 32'd0);
    do_instr({12'd0, 5'd0, 3'b010, 5'd1, 7'b0000011}, 0, 1'b1);
    do_instr(i_type(12'hfff, 5'd1, 3'd0, 5'd4), 2, 1'b1);
    do_instr(i_type(12'h41f, 5'd4, 3'd5, 5'd5), 0, 1'b1);
    do_instr(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd4), 0, 1'b0);
    do_instr(r_type(7'h01, 5'd2, 5'd1, 3'd0, 5'd6), 0, 1'b1);
    do_instr(r_type(7'h00, 5'd2, 5'd1, 3'd1, 5'd6), 15, 1'b1);

    // Random traffic over a small register window so values get reused.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] ins;
      logic [2:0]  f3;
      logic [6:0]  f7, opc;
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] imm;
      int          kind, dly;
      kind = $urandom_range(0, 9);
      f3   = 3'($urandom);
      rd   = 5'($urandom_range(0, 7));
      rs1  = 5'($urandom_range(0, 7));
      rs2  = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) f7 = 7'($urandom);
      else f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (kind < 4) begin
        ins = r_type(f7, rs2, rs1, f3, rd);
      end else if (kind < 9) begin
        imm = 12'($urandom);
        if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = f7;
        ins = i_type(imm, rs1, f3, rd);
      end else begin
        opc = 7'($urandom);
        if (opc == 7'b0110011 || opc == 7'b0010011) opc = 7'b0000011;
        ins = {25'($urandom), opc};
      end
      dly = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4);
      do_instr(ins, dly, 1'b1);
    end

    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk("regfile_sweep", dbg_data, mregs[i]);
    end

    // Asynchronous reset in the middle of WAIT, then a stale exec pulse.
    tick();
    in_valid = 1'b1;
    in_instr = i_type(12'd100, 5'd0, 3'd0, 5'd5);
    tick();
    in_valid = 1'b0;
    tick();
    chk1("pre_reset_in_wait", in_ready, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk1("async_reset_ready", in_ready, 1'b1);
    chk1("async_reset_enable", alu_enable, 1'b0);
    chk("async_reset_op1", alu_op1, 32'd0);
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    for (int i = 1; i < 8; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk("async_reset_reg", dbg_data, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    alu_instr_exec = 1'b1;
    alu_result     = 32'hdead_beef;
    tick();
    alu_instr_exec = 1'b0;
    dbg_addr       = 5'd5;
    #1;
    chk("late_exec_ignored", dbg_data, 32'd0);
    chk1("late_exec_no_enable", alu_enable, 1'b0);
    chk1("late_exec_ready", in_ready, 1'b1);
    do_instr(i_type(12'h800, 5'd0, 3'd0, 5'd5), 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
